fwd_hazard_unit: RTL and testbench

Parametrised successor to the combinational EX-stage forwarding logic. It keeps an internal shadow of the destination registers of in-flight instructions for DEPTH stages past EX (stage 1 = MEM, stage 2 = WB, ...). From that shadow it generates nearest-producer forward selects for NUM_SRC EX operands. It detects load-use hazards for a configurable load latency and drives a multi-cycle stall through a counter FSM. It also keeps a stall-cycle performance counter.

---
 rtl/fwd_hazard_unit.sv | 166 ++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit.
// Keeps a shadow of the destination registers of the DEPTH instructions past EX.
// From that shadow it picks the nearest producer for each EX operand.
// It detects load-use hazards for a configurable load latency and holds the
// stall for the required number of bubbles. It also counts stalled cycles.
module fwd_hazard_unit #(
  parameter int ADDR_W   = 5,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 2,
  localparam int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_ex_valid,
  input  logic [ADDR_W-1:0]         i_ex_rd,
  input  logic                      i_ex_regwrite,
  input  logic                      i_ex_memread,
  input  logic [NUM_SRC*ADDR_W-1:0] i_ex_rs,
  input  logic                      i_id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] i_id_rs,
  input  logic [NUM_SRC-1:0]        i_id_rs_used,
  input  logic                      i_flush,
  output logic [NUM_SRC*SEL_W-1:0]  o_fwd_sel,
  output logic                      o_stall,
  output logic [31:0]               o_stall_cycles
);

  // Wide enough to hold the largest bubble count, LOAD_LAT-1.
  localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] rd;
    logic              wr;
    logic              ld;
  } shadow_t;

  typedef enum logic {S_IDLE, S_STALL} state_t;

  shadow_t          r_st [1:DEPTH];
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_bubbles;
  logic             w_detect;
  logic             w_stall;
  logic [31:0]      r_stall_cycles;

  // True when some operand that ID actually reads names register rd.
  function automatic logic id_reads(input logic [NUM_SRC*ADDR_W-1:0] rs,
                                    input logic [NUM_SRC-1:0]        used,
                                    input logic [ADDR_W-1:0]         rd);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (used[i] && (rs[i*ADDR_W +: ADDR_W] == rd)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Shift the EX instruction into the shadow; a flushed EX enters as a bubble.
  // NOTE: the shadow is a handful of flops, so every field is reset, not just v,
  // which keeps rd/wr/ld deterministic straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) r_st[k] <= '0;
    end else begin
      // NOTE: sequential state uses <= so every stage samples the pre-edge values.
      r_st[1] <= '{v: i_ex_valid & ~i_flush, rd: i_ex_rd,
                   wr: i_ex_regwrite, ld: i_ex_memread};
      for (int k = 2; k <= DEPTH; k++) r_st[k] <= r_st[k-1];
    end
  end

  // Nearest-producer select: scan oldest to newest so the youngest match wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (r_st[k].v && r_st[k].wr && (r_st[k].rd != '0) &&
            (r_st[k].rd == i_ex_rs[i*ADDR_W +: ADDR_W])) begin
          o_fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
        end
      end
    end
  end

  // Load-use detect: bubbles owed to the nearest matching load still too young.
  always_comb begin
    w_bubbles = '0;
    for (int d = LOAD_LAT - 2; d >= 1; d--) begin
      if (r_st[d].v && r_st[d].ld && r_st[d].wr && (r_st[d].rd != '0) &&
          id_reads(i_id_rs, i_id_rs_used, r_st[d].rd)) begin
        w_bubbles = CNT_W'(LOAD_LAT - 1 - d);
      end
    end
    if ((LOAD_LAT > 1) && i_ex_valid && i_ex_memread && i_ex_regwrite &&
        (i_ex_rd != '0) && id_reads(i_id_rs, i_id_rs_used, i_ex_rd)) begin
      w_bubbles = CNT_W'(LOAD_LAT - 1);
    end
    if (!i_id_valid || i_flush) w_bubbles = '0;
    w_detect = (w_bubbles != '0);
  end

  // Stall FSM state and remaining-bubble counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and stall output; flush and reset override everything.
  always_comb begin
    w_stall     = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_stall = w_detect;
        if (w_detect && (w_bubbles > CNT_W'(1))) begin
          w_state_nxt = S_STALL;
          w_cnt_nxt   = w_bubbles - CNT_W'(1);
        end
      end
      S_STALL: begin
        w_stall = 1'b1;
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    if (i_flush) begin
      w_stall     = 1'b0;
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end
    if (rst) w_stall = 1'b0;
  end

  // Performance counter of stalled cycles; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_stall        = w_stall;
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (defaults, and DEPTH=3/LOAD_LAT=3)
// share one directed stimulus stream. A history-based model predicts every
// output each cycle; literal expectations pin the key scenarios.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        nxt_rst;
  logic        i_ex_valid;
  logic [4:0]  i_ex_rd;
  logic        i_ex_regwrite;
  logic        i_ex_memread;
  logic [9:0]  i_ex_rs;
  logic        i_id_valid;
  logic [9:0]  i_id_rs;
  logic [1:0]  i_id_rs_used;
  logic        i_flush;

  logic [3:0]  sel_a, sel_b;
  logic        stall_a, stall_b;
  logic [31:0] sc_a, sc_b;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.ADDR_W(5), .NUM_SRC(2), .DEPTH(2), .LOAD_LAT(2)) dut_a (
    .clk(clk), .rst(rst), .i_ex_valid(i_ex_valid), .i_ex_rd(i_ex_rd),
    .i_ex_regwrite(i_ex_regwrite), .i_ex_memread(i_ex_memread), .i_ex_rs(i_ex_rs),
    .i_id_valid(i_id_valid), .i_id_rs(i_id_rs), .i_id_rs_used(i_id_rs_used),
    .i_flush(i_flush), .o_fwd_sel(sel_a), .o_stall(stall_a), .o_stall_cycles(sc_a)
  );

  fwd_hazard_unit #(.ADDR_W(5), .NUM_SRC(2), .DEPTH(3), .LOAD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .i_ex_valid(i_ex_valid), .i_ex_rd(i_ex_rd),
    .i_ex_regwrite(i_ex_regwrite), .i_ex_memread(i_ex_memread), .i_ex_rs(i_ex_rs),
    .i_id_valid(i_id_valid), .i_id_rs(i_id_rs), .i_id_rs_used(i_id_rs_used),
    .i_flush(i_flush), .o_fwd_sel(sel_b), .o_stall(stall_b), .o_stall_cycles(sc_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- model: history of instructions that left EX ----------------
  // Index 0 models the default config, index 1 the DEPTH=3/LOAD_LAT=3 config.
  logic        m_v  [2][1:3];
  logic [4:0]  m_rd [2][1:3];
  logic        m_wr [2][1:3];
  logic        m_ld [2][1:3];
  int          m_owed [2];   // stall cycles still owed after the current one
  logic [31:0] m_sc [2];
  int          mb;
  logic        ms;

  function automatic int dep_of(input int c);
    return (c == 0) ? 2 : 3;
  endfunction

  function automatic int lat_of(input int c);
    return (c == 0) ? 2 : 3;
  endfunction

  function automatic logic id_uses(input logic [4:0] r);
    return (i_id_rs_used[0] && (i_id_rs[4:0] == r)) ||
           (i_id_rs_used[1] && (i_id_rs[9:5] == r));
  endfunction

  function automatic int exp_sel(input int c, input int i);
    logic [4:0] src;
    src = (i == 1) ? i_ex_rs[9:5] : i_ex_rs[4:0];
    for (int k = 1; k <= dep_of(c); k++)
      if (m_v[c][k] && m_wr[c][k] && (m_rd[c][k] != 0) && (m_rd[c][k] == src)) return k;
    return 0;
  endfunction

  // Bubbles needed so the ID consumer never reaches EX before load data is ready.
  function automatic int exp_bub(input int c);
    int b;
    b = 0;
    if (!i_id_valid || i_flush) return 0;
    if (i_ex_valid && i_ex_memread && i_ex_regwrite && (i_ex_rd != 0) && id_uses(i_ex_rd))
      b = lat_of(c) - 1;
    for (int d = 1; d <= lat_of(c) - 2; d++)
      if (m_v[c][d] && m_ld[c][d] && m_wr[c][d] && (m_rd[c][d] != 0) &&
          id_uses(m_rd[c][d]) && (lat_of(c) - 1 - d > b))
        b = lat_of(c) - 1 - d;
    return b;
  endfunction

  function automatic logic exp_stall(input int c);
    if (rst || i_flush) return 1'b0;
    if (m_owed[c] > 0) return 1'b1;
    return exp_bub(c) > 0;
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        for (int k = 1; k <= 3; k++) begin
          m_v[c][k] = 1'b0; m_rd[c][k] = '0; m_wr[c][k] = 1'b0; m_ld[c][k] = 1'b0;
        end
        m_owed[c] = 0;
        m_sc[c]   = '0;
      end else begin
        ms = exp_stall(c);
        mb = exp_bub(c);
        if (ms) m_sc[c] = m_sc[c] + 1;
        if (i_flush)            m_owed[c] = 0;
        else if (m_owed[c] > 0) m_owed[c] = m_owed[c] - 1;
        else if (mb > 0)        m_owed[c] = mb - 1;
        for (int k = 3; k >= 2; k--) begin
          m_v[c][k] = m_v[c][k-1]; m_rd[c][k] = m_rd[c][k-1];
          m_wr[c][k] = m_wr[c][k-1]; m_ld[c][k] = m_ld[c][k-1];
        end
        m_v[c][1]  = i_ex_valid & ~i_flush;
        m_rd[c][1] = i_ex_rd;
        m_wr[c][1] = i_ex_regwrite;
        m_ld[c][1] = i_ex_memread;
      end
    end
  end

  // Compare every output of both instances against the model mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("sel_a_op%0d", i), 32'(sel_a[i*2 +: 2]), 32'(exp_sel(0, i)));
      check($sformatf("sel_b_op%0d", i), 32'(sel_b[i*2 +: 2]), 32'(exp_sel(1, i)));
    end
    check("stall_a", 32'(stall_a), 32'(exp_stall(0)));
    check("stall_b", 32'(stall_b), 32'(exp_stall(1)));
    check("cycles_a", sc_a, m_sc[0]);
    check("cycles_b", sc_b, m_sc[1]);
  end

  // ---------------- stimulus ----------------
  // One pipeline cycle: drive after the edge, return at the following negedge.
  task automatic cyc(input logic ev, input logic [4:0] rd, input logic wr, input logic ld,
                     input logic [4:0] rs0, input logic [4:0] rs1,
                     input logic idv, input logic [4:0] irs0, input logic [4:0] irs1,
                     input logic [1:0] used, input logic fl);
    @(posedge clk);
    #1;
    rst           = nxt_rst;
    i_ex_valid    = ev;
    i_ex_rd       = rd;
    i_ex_regwrite = wr;
    i_ex_memread  = ld;
    i_ex_rs       = {rs1, rs0};
    i_id_valid    = idv;
    i_id_rs       = {irs1, irs0};
    i_id_rs_used  = used;
    i_flush       = fl;
    @(negedge clk);
  endtask

  task automatic bub();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
  endtask

  initial begin
    rst = 1'b1; nxt_rst = 1'b0;
    i_ex_valid = 0; i_ex_rd = 0; i_ex_regwrite = 0; i_ex_memread = 0; i_ex_rs = 0;
    i_id_valid = 0; i_id_rs = 0; i_id_rs_used = 0; i_flush = 0;
    @(negedge clk);
    check("reset_stall", 32'(stall_a), 32'd0);
    check("reset_sel",   32'(sel_a),   32'd0);
    check("reset_cycles", sc_a, 32'd0);

    // Basic forwarding: add x5, sub reads x5 (stage 1), and reads x5 (stage 2).
    cyc(1, 5, 1, 0, 1, 2, 0, 0, 0, 2'b00, 0);
    cyc(1, 6, 1, 0, 5, 1, 0, 0, 0, 2'b00, 0);
    check("t1_sel0_stage1", 32'(sel_a[1:0]), 32'd1);
    cyc(1, 7, 1, 0, 2, 5, 0, 0, 0, 2'b00, 0);
    check("t1_sel1_stage2", 32'(sel_a[3:2]), 32'd2);
    check("t1_sel0_none",   32'(sel_a[1:0]), 32'd0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    check("t1_x0_not_producer", 32'(sel_a), 32'd0);

    // Priority: two x7 producers, then the nearer one stops writing.
    cyc(1, 7, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    cyc(1, 7, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    cyc(1, 7, 0, 0, 7, 0, 0, 0, 0, 2'b00, 0);
    check("t2_nearest_wins", 32'(sel_a[1:0]), 32'd1);
    cyc(0, 0, 0, 0, 7, 0, 0, 0, 0, 2'b00, 0);
    check("t2_skip_nonwriter", 32'(sel_a[1:0]), 32'd2);
    bub(); bub(); bub();

    // Load-use with default latency: one bubble, then forward from stage 2.
    cyc(1, 3, 1, 1, 0, 0, 1, 3, 0, 2'b01, 0);
    check("t3_stall", 32'(stall_a), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 1, 3, 0, 2'b01, 0);
    check("t3_stall_released", 32'(stall_a), 32'd0);
    check("t3_cycles", sc_a, 32'd1);
    cyc(1, 4, 1, 0, 3, 0, 0, 0, 0, 2'b00, 0);
    check("t3_fwd_load", 32'(sel_a[1:0]), 32'd2);
    cyc(1, 3, 1, 1, 0, 0, 1, 3, 0, 2'b00, 0);
    check("t3_unused_no_stall", 32'(stall_a), 32'd0);
    check("t3_cycles_hold", sc_a, 32'd1);
    bub(); bub(); bub();

    // LOAD_LAT=3: load in EX needs two bubbles, load in stage 1 needs one.
    cyc(1, 9, 1, 1, 0, 0, 1, 9, 0, 2'b01, 0);
    check("t4_stall_first", 32'(stall_b), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 0, 2'b01, 0);
    check("t4_stall_second", 32'(stall_b), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 0, 2'b01, 0);
    check("t4_stall_done", 32'(stall_b), 32'd0);
    cyc(1, 10, 1, 0, 9, 0, 0, 0, 0, 2'b00, 0);
    check("t4_fwd_stage3", 32'(sel_b[1:0]), 32'd3);
    cyc(1, 11, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 11, 2'b10, 0);
    check("t4_stage1_load_stall", 32'(stall_b), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 11, 2'b10, 0);
    check("t4_stage2_load_ok", 32'(stall_b), 32'd0);
    bub();

    // Flush in the second stall cycle kills the stall and the EX instruction.
    cyc(1, 9, 1, 1, 0, 0, 1, 9, 0, 2'b01, 0);
    cyc(1, 12, 1, 0, 0, 0, 1, 9, 0, 2'b01, 1);
    check("t5_flush_stall", 32'(stall_b), 32'd0);
    cyc(1, 13, 1, 0, 12, 0, 0, 0, 0, 2'b00, 0);
    check("t5_flushed_not_producer", 32'(sel_b[1:0]), 32'd0);
    check("t5_cycles", sc_b, 32'd6);

    // Reset in the middle of a stall with a full shadow.
    cyc(1, 14, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    cyc(1, 15, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    cyc(1, 16, 1, 1, 0, 0, 1, 16, 0, 2'b01, 0);
    check("t6_stall_before_reset", 32'(stall_b), 32'd1);
    nxt_rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 1, 16, 0, 2'b01, 0);
    check("t6_stall_in_reset", 32'(stall_b), 32'd0);
    nxt_rst = 1'b0;
    cyc(1, 17, 1, 0, 16, 15, 0, 0, 0, 2'b00, 0);
    check("t6_sel_cleared",    32'(sel_b),   32'd0);
    check("t6_cycles_cleared", sc_b,         32'd0);
    check("t6_no_stall",       32'(stall_b), 32'd0);
    cyc(1, 18, 1, 0, 17, 0, 0, 0, 0, 2'b00, 0);
    check("t6_fwd_resumes", 32'(sel_b[1:0]), 32'd1);
    bub();

    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
